// File: rtl/mdu_rv32m_if.sv
// Operand/result bundle between the issue stage, the multiply/divide unit and write-back.
// The master drives the operation request; the slave returns busy/done and the result.
interface mdu_rv32m_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_in;
    logic [XLEN-1:0] rs2_in;
    logic [4:0]      rd_addr_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_addr_out;
    logic            rd_write;

    modport master (
        output start, funct3, rs1_in, rs2_in, rd_addr_in,
        input  busy, done, result, rd_addr_out, rd_write
    );

    modport slave (
        input  start, funct3, rs1_in, rs2_in, rd_addr_in,
        output busy, done, result, rd_addr_out, rd_write
    );
endinterface

// File: rtl/mdu_rv32m.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes.
// Latency: start at edge k, done pulses in the cycle after edge k+33 for every op.
// Backpressure: busy stalls the pipeline; start is only accepted while idle, never queued.
module mdu_rv32m #(
    parameter int XLEN = 32
) (
    input  logic        clock,
    input  logic        reset,
    mdu_rv32m_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic            neg_q, neg_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div_zero_q, div_zero_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic              sgn1, sgn2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_fin;
    logic [XLEN-1:0]   quo_fin, rem_fin;

    always_comb begin
        sgn1 = bus.rs1_in[XLEN-1] &
               ((bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM));
        sgn2 = bus.rs2_in[XLEN-1] &
               ((bus.funct3 == F_MULH) || (bus.funct3 == F_DIV) || (bus.funct3 == F_REM));
        mag1 = sgn1 ? -bus.rs1_in : bus.rs1_in;
        mag2 = sgn2 ? -bus.rs2_in : bus.rs2_in;

        // Multiply: {hi,lo} holds partial product over the shifting multiplier.
        mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? op_q : {XLEN{1'b0}})};
        // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, op_q};

        prod     = {hi_q, lo_q};
        prod_fin = neg_q ? -prod : prod;
        quo_fin  = neg_q ? -lo_q : lo_q;
        rem_fin  = neg_rem_q ? -hi_q : hi_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        f3_d       = f3_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rs1_d      = rs1_q;
        result_d   = result_q;
        rd_d       = rd_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = CALC;
                    cnt_d      = '0;
                    f3_d       = bus.funct3;
                    rs1_d      = bus.rs1_in;
                    rd_d       = bus.rd_addr_in;
                    hi_d       = '0;
                    op_d       = bus.funct3[2] ? mag2 : mag1;
                    lo_d       = bus.funct3[2] ? mag1 : mag2;
                    neg_d      = sgn1 ^ sgn2;
                    neg_rem_d  = sgn1;
                    div_zero_d = (bus.rs2_in == '0);
                    ovf_d      = ((bus.funct3 == F_DIV) || (bus.funct3 == F_REM)) &&
                                 (bus.rs1_in == MIN_NEG) && (bus.rs2_in == '1);
                end
            end
            CALC: begin
                if (f3_q[2]) begin
                    if (div_ge) begin
                        hi_d = div_shift[XLEN-1:0] - op_q;
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!f3_q[2]) begin
                    result_d = (f3_q[1:0] == F_MUL[1:0]) ? prod_fin[XLEN-1:0]
                                                         : prod_fin[2*XLEN-1:XLEN];
                end else if (div_zero_q) begin
                    result_d = f3_q[1] ? rs1_q : '1;
                end else if (ovf_q) begin
                    result_d = f3_q[1] ? '0 : MIN_NEG;
                end else begin
                    result_d = f3_q[1] ? rem_fin : quo_fin;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            f3_q       <= '0;
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            rs1_q      <= '0;
            result_q   <= '0;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            f3_q       <= f3_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rs1_q      <= rs1_d;
            result_q   <= result_d;
            rd_q       <= rd_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.rd_addr_out = rd_q;
    assign bus.rd_write    = done_q && (rd_q != 5'd0);
endmodule

// File: tb/tb_mdu_rv32m.sv
// Directed bench for mdu_rv32m: hand-computed vectors, latency, control and reset-abort scenarios.
module tb_mdu_rv32m;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // done is first seen #1 after the 33rd edge following the start edge.
    localparam int LAT = 33;

    mdu_rv32m_if #(.XLEN(32)) bus ();
    mdu_rv32m dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // Called #1 after an edge: drives start now, so the next edge is the start edge.
    // Operands are scrambled right after acceptance to prove they are latched.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output logic busy_ok);
        bus.start = 1'b1; bus.funct3 = f; bus.rs1_in = a; bus.rs2_in = b; bus.rd_addr_in = rd;
        @(posedge clock); #1;
        bus.start = 1'b0; bus.rs1_in = ~a; bus.rs2_in = ~b ^ 32'h5; bus.funct3 = ~f; bus.rd_addr_in = ~rd;
        busy_ok = (bus.busy === 1'b1);
        lat = -1;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1) begin
                lat = n;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
            end else if (bus.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.rd_write} !== 3'b000 || bus.result !== 32'h0 || bus.rd_addr_out !== 5'h0) begin
            errors++;
            $display("FAIL reset busy/done/wr=%b result=%h rd=%h, required 000/0/0",
                     {bus.busy, bus.done, bus.rd_write}, bus.result, bus.rd_addr_out);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_vectors(input string name, input logic [2:0] fv [], input logic [31:0] av [],
                                input logic [31:0] bv [], input logic [31:0] ev []);
        int lat; logic bok;
        for (int i = 0; i < fv.size(); i++) begin
            run_op(fv[i], av[i], bv[i], 5'd5 + 5'(i), lat, bok);
            checks++;
            if (lat !== LAT || !bok || bus.result !== ev[i] || bus.rd_addr_out !== 5'd5 + 5'(i) || bus.rd_write !== 1'b1) begin
                errors++;
                $display("FAIL %s[%0d] f3=%b lat=%0d busy_ok=%b result=%h rd=%0d wr=%b, required lat=%0d result=%h rd=%0d wr=1",
                         name, i, fv[i], lat, bok, bus.result, bus.rd_addr_out, bus.rd_write, LAT, ev[i], 5 + i);
            end
            @(posedge clock); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.rd_write !== 1'b0 || bus.result !== ev[i]) begin
                errors++;
                $display("FAIL %s[%0d]_pulse done=%b wr=%b result=%h, required 0/0/%h",
                         name, i, bus.done, bus.rd_write, bus.result, ev[i]);
            end
        end
    endtask

    task automatic test_mul();
        test_vectors("mul", '{3'b000}, '{32'd7}, '{32'hFFFFFFFD}, '{32'hFFFFFFEB});
    endtask

    task automatic test_mulh();
        test_vectors("mulh", '{3'b001, 3'b011, 3'b010, 3'b011},
                     '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000},
                     '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000},
                     '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001});
    endtask

    task automatic test_div();
        test_vectors("div", '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110},
                     '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd20, 32'd20, 32'd20, 32'd20},
                     '{32'd6, 32'd6, 32'd6, 32'd6, 32'hFFFFFFFA, 32'hFFFFFFFA},
                     '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'd3, 32'd2, 32'hFFFFFFFD, 32'd2});
    endtask

    task automatic test_special();
        test_vectors("special", '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110},
                     '{32'd5, 32'd5, 32'd5, 32'd5, 32'h80000000, 32'h80000000},
                     '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF},
                     '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0});
    endtask

    task automatic test_x0();
        int lat; logic bok;
        run_op(3'b000, 32'd2, 32'd3, 5'd0, lat, bok);
        checks++;
        if (lat !== LAT || bus.done !== 1'b1 || bus.rd_write !== 1'b0 || bus.result !== 32'd6 || bus.rd_addr_out !== 5'd0) begin
            errors++;
            $display("FAIL x0 lat=%0d done=%b wr=%b result=%h rd=%0d, required lat=%0d done=1 wr=0 result=6 rd=0",
                     lat, bus.done, bus.rd_write, bus.result, bus.rd_addr_out, LAT);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_start_while_busy();
        int lat = -1; int extra = 0;
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1_in = 32'd9; bus.rs2_in = 32'd9; bus.rd_addr_in = 5'd7;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            if (n == 10) begin
                bus.start = 1'b1; bus.rs1_in = 32'd1; bus.rs2_in = 32'd1; bus.rd_addr_in = 5'd3;
            end
            @(posedge clock); #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) lat = n;
        end
        checks++;
        if (lat !== LAT || bus.result !== 32'd81 || bus.rd_addr_out !== 5'd7) begin
            errors++;
            $display("FAIL busy_start lat=%0d result=%h rd=%0d, required lat=%0d result=51 rd=7",
                     lat, bus.result, bus.rd_addr_out, LAT);
        end
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_start_queued extra_done_or_busy_cycles=%0d, required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2; logic bok1, bok2;
        run_op(3'b101, 32'd100, 32'd7, 5'd9, lat1, bok1);
        checks++;
        if (lat1 !== LAT || !bok1 || bus.result !== 32'd14) begin
            errors++;
            $display("FAIL b2b_first lat=%0d busy_ok=%b result=%h, required lat=%0d result=e", lat1, bok1, bus.result, LAT);
        end
        run_op(3'b111, 32'd100, 32'd7, 5'd10, lat2, bok2);
        checks++;
        if (lat2 !== LAT || !bok2 || bus.result !== 32'd2 || bus.rd_addr_out !== 5'd10 || bus.rd_write !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second lat=%0d busy_ok=%b result=%h rd=%0d wr=%b, required lat=%0d result=2 rd=10 wr=1",
                     lat2, bok2, bus.result, bus.rd_addr_out, bus.rd_write, LAT);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_abort();
        int seen = 0; int lat; logic bok;
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.rs1_in = 32'd1000; bus.rs2_in = 32'd10; bus.rd_addr_in = 5'd4;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0 || bus.rd_write !== 1'b0) begin
            errors++;
            $display("FAIL abort_state busy=%b done=%b result=%h wr=%b, required 0/0/0/0",
                     bus.busy, bus.done, bus.result, bus.rd_write);
        end
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1 || bus.rd_write === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done done_cycles=%0d, required 0", seen);
        end
        run_op(3'b011, 32'd3, 32'd5, 5'd6, lat, bok);
        checks++;
        if (lat !== LAT || !bok || bus.result !== 32'h0) begin
            errors++;
            $display("FAIL abort_then_mulhu lat=%0d busy_ok=%b result=%h, required lat=%0d result=0", lat, bok, bus.result, LAT);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        bus.start = 1'b0; bus.funct3 = 3'b000; bus.rs1_in = '0; bus.rs2_in = '0; bus.rd_addr_in = '0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_x0();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_rv32m.md
Name: mdu_rv32m

Overview:
- Iterative RV32M multiply/divide unit on the execute path, between register-file read and write-back.
- Captures rs1/rs2 operand values (read asynchronously from the register file) and the destination address when started.
- Computes over a fixed number of cycles and returns result, rd_addr_out and rd_write to the write-back mux that drives the register file's rd_in, rd_addr and cu_rdwrite.
- The control unit stalls the pipeline while busy is high.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; the latency figures below assume 32.

Ports:
- clock  input  1  global clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled on posedge while idle
- funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_in  input  32  operand A (dividend / multiplicand)
- rs2_in  input  32  operand B (divisor / multiplier)
- rd_addr_in  input  5  destination register of the operation
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result is valid in the same cycle
- result  output  32  result value, held until the next done
- rd_addr_out  output  5  destination address, held with result
- rd_write  output  1  write enable to the register file: done AND (rd_addr_out != 0)

Behaviour:
- Reset: state IDLE, busy=0, done=0, rd_write=0, result=0, rd_addr_out=0, iteration counter=0.
- Reset mid-operation aborts the operation. No done or rd_write is produced for it.
- States and transitions:
  - IDLE: at posedge with start=1, latch funct3, rs1_in, rs2_in, rd_addr_in. Go to CALC with counter=0. Operands are not re-read after this point.
  - CALC: one iteration per cycle. counter increments each cycle; leave CALC after exactly 32 iterations (counter 31 -> FIN).
  - FIN: apply sign correction and special cases, register result and rd_addr_out, pulse done, return to IDLE.
- Latency:
  - start sampled at edge k -> busy=1 from edge k through edge k+33.
  - done=1 in the cycle after edge k+33, for one cycle, with busy=0 in that cycle.
  - Latency is identical for every funct3 and every operand value, including special cases.
- Back-to-back: start may be asserted in the same cycle done is high. That start is accepted, since the state is IDLE.
- start while busy is ignored and is not queued.
- Multiply:
  - Shift-add on operand magnitudes, producing a 64-bit product.
  - Sign rules: MULH treats both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU and MUL treat operands as unsigned (MUL's low 32 bits are sign-independent).
  - Negate the 64-bit product in FIN when the operand signs differ.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - Restoring division on magnitudes; DIV and REM use signed operands.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
  - Quotient truncates toward zero.
- Special cases, resolved in FIN and overriding the datapath:
  - Divisor 0: DIV and DIVU return 0xFFFFFFFF; REM and REMU return rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Writes to x0: rd_addr_in=0 still produces done and updates result, but rd_write stays 0.
- No exceptions or flags are generated.

Test Plan:
- MUL: reset, start with funct3=000, rs1=7, rs2=0xFFFFFFFD (-3), rd=5 at edge k.
  -> busy=1 for edges k..k+33, then done=1 one cycle.
  -> result=0xFFFFFFEB, rd_addr_out=5, rd_write=1.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0x00010000 x 0x00010000 -> 0x00000001.
- Signed and unsigned divide:
  - DIV -20/6 -> 0xFFFFFFFD; REM -20/6 -> 0xFFFFFFFE.
  - DIVU 20/6 -> 3; REMU 20/6 -> 2.
  - DIV 20/-6 -> 0xFFFFFFFD; REM 20/-6 -> 2.
- Special cases, each with done exactly 34 cycles after the start edge:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Control:
  - Change rs1_in/rs2_in mid-operation -> result unaffected.
  - Assert start at edge k+10 while busy -> ignored, only one done.
  - rd_addr_in=0 -> done=1 with rd_write=0.
  - Start a new op in the done cycle -> second done 34 cycles later.
- Reset abort: assert reset for one cycle at edge k+15 of a DIV.
  -> busy=0, done=0, result=0 from the next cycle; no done within 40 cycles.
  -> A subsequent MULHU 3x5 returns 0 with normal latency.
